// File: rtl/digit_scan_ctrl.sv
// Scan sequencer feeding decoder_24: steps a[1:0] over the enabled slots of slot_mask.
// Optional SCAN_BLANK_EN inserts a one-cycle blanking state between slots.
module digit_scan_ctrl #(
   parameter int unsigned PRESCALE = 4,
   parameter int unsigned CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] slot_mask,
   output logic [1:0] a,
   output logic       a_valid,
   output logic       frame_done
);

   localparam int unsigned SLOTS = 4;

`ifdef SCAN_BLANK_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BLANK = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             term_cnt;
   logic [1:0]       first_slot;
   logic [1:0]       next_slot;
   logic             next_wrap;

   assign term_cnt = (cnt == CNT_W'(PRESCALE - 1));

   // Lowest enabled slot; used when a scan starts from IDLE.
   always_comb begin
      first_slot = 2'd0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (slot_mask[i]) first_slot = 2'(i);
      end
   end

   // Circular search for the next enabled slot after a; closest offset wins.
   always_comb begin
      logic [1:0] cand;
      next_slot = a;
      cand      = a;
      for (int k = SLOTS; k >= 1; k--) begin
         cand = a + 2'(k);
         if (slot_mask[cand]) next_slot = cand;
      end
      next_wrap = (next_slot <= a);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a          <= 2'd0;
         a_valid    <= 1'b0;
         frame_done <= 1'b0;
         cnt        <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               a_valid <= 1'b0;
               if (en && (slot_mask != 4'd0)) begin
                  state   <= RUN;
                  a       <= first_slot;
                  a_valid <= 1'b1;
               end
            end

            RUN: begin
               if (!en) begin
                  state   <= IDLE;
                  a_valid <= 1'b0;
                  cnt     <= '0;
               end else if (term_cnt) begin
                  cnt <= '0;
                  if (slot_mask == 4'd0) begin
                     state   <= IDLE;
                     a_valid <= 1'b0;
                  end else begin
                     a          <= next_slot;
                     frame_done <= next_wrap;
`ifdef SCAN_BLANK_EN
                     state      <= BLANK;
                     a_valid    <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

`ifdef SCAN_BLANK_EN
            // One dark cycle with a already on the next slot.
            BLANK: begin
               cnt <= '0;
               if (!en) begin
                  state   <= IDLE;
                  a_valid <= 1'b0;
               end else begin
                  state   <= RUN;
                  a_valid <= 1'b1;
               end
            end
`endif

            default: begin
               state   <= IDLE;
               a_valid <= 1'b0;
               cnt     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl: per-cycle reference model feeding a scoreboard queue.
module tb_digit_scan_ctrl;

   localparam int unsigned P = 4;

   typedef struct packed {
      logic [1:0] a;
      logic       av;
      logic       fd;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [3:0] slot_mask;
   logic [1:0] a;
   logic       a_valid;
   logic       frame_done;

   digit_scan_ctrl #(.PRESCALE(P), .CNT_W(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .slot_mask  (slot_mask),
      .a          (a),
      .a_valid    (a_valid),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   exp_t sb[$];

   // Reference model state: 0 idle, 1 run, 2 blank.
   int         m_state = 0;
   int         m_cnt   = 0;
   logic [1:0] m_a     = 2'd0;
   logic       m_av    = 1'b0;
   logic       m_fd    = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, obs, exp_v);
   endtask

   task automatic model_edge();
      int nxt;
      m_fd = 1'b0;
      if (rst) begin
         m_state = 0; m_a = 2'd0; m_av = 1'b0; m_cnt = 0;
      end else begin
         case (m_state)
            0: begin
               m_cnt = 0;
               if (en && slot_mask != 4'd0) begin
                  nxt = -1;
                  for (int i = 0; i < 4; i++) if (nxt < 0 && slot_mask[i]) nxt = i;
                  m_a = 2'(nxt); m_av = 1'b1; m_state = 1;
               end
            end
            1: begin
               if (!en) begin
                  m_state = 0; m_av = 1'b0; m_cnt = 0;
               end else if (m_cnt == P - 1) begin
                  m_cnt = 0;
                  if (slot_mask == 4'd0) begin
                     m_state = 0; m_av = 1'b0;
                  end else begin
                     nxt = -1;
                     for (int k = 1; k <= 4; k++)
                        if (nxt < 0 && slot_mask[(int'(m_a) + k) % 4]) nxt = (int'(m_a) + k) % 4;
                     m_fd = (nxt <= int'(m_a));
                     m_a  = 2'(nxt);
`ifdef SCAN_BLANK_EN
                     m_state = 2; m_av = 1'b0;
`endif
                  end
               end else begin
                  m_cnt++;
               end
            end
            default: begin
               m_cnt = 0;
               if (!en) begin
                  m_state = 0; m_av = 1'b0;
               end else begin
                  m_state = 1; m_av = 1'b1;
               end
            end
         endcase
      end
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      e.a = m_a; e.av = m_av; e.fd = m_fd;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = sb.pop_front();
      chk("a", int'(a), int'(e.a));
      chk("a_valid", int'(a_valid), int'(e.av));
      chk("frame_done", int'(frame_done), int'(e.fd));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int found;

   initial begin
      rst = 1'b1; en = 1'b0; slot_mask = 4'hF;

      // Reset then idle with en low.
      steps(2);
      rst = 1'b0;
      steps(6);
      chk("idle_a", int'(a), 0);
      chk("idle_av", int'(a_valid), 0);

      // Full scan.
      en = 1'b1;
      step();
      chk("av_after_en", int'(a_valid), 1);
      chk("start_slot", int'(a), 0);
      steps(40);

      // Sparse mask 1010.
      slot_mask = 4'b1010;
      steps(30);

      // Single slot, then mask change two cycles into a slot.
      slot_mask = 4'b0100;
      steps(14);
      found = 0;
      for (int g = 0; g < 20 && found == 0; g++) begin
         if (m_state == 1 && m_cnt == 2) found = 1; else step();
      end
      chk("find_cnt2", found, 1);
      slot_mask = 4'b0001;
      steps(10);

      // en drop at a=2, counter=1.
      slot_mask = 4'hF;
      found = 0;
      for (int g = 0; g < 60 && found == 0; g++) begin
         if (m_state == 1 && m_a == 2'd2 && m_cnt == 1) found = 1; else step();
      end
      chk("find_a2", found, 1);
      en = 1'b0;
      step();
      chk("en_drop_av", int'(a_valid), 0);
      chk("en_drop_a", int'(a), 2);
      steps(3);
      slot_mask = 4'b0110;
      en = 1'b1;
      step();
      chk("restart_a", int'(a), 1);
      steps(8);

      // Mask goes to zero exactly at terminal count.
      found = 0;
      for (int g = 0; g < 20 && found == 0; g++) begin
         if (m_state == 1 && m_cnt == P - 1) found = 1; else step();
      end
      chk("find_tc", found, 1);
      slot_mask = 4'd0;
      steps(4);
      chk("mask0_av", int'(a_valid), 0);

      // Reset pulse mid-slot.
      slot_mask = 4'b1100;
      steps(2);
      found = 0;
      for (int g = 0; g < 20 && found == 0; g++) begin
         if (m_state == 1 && m_cnt == 2) found = 1; else step();
      end
      chk("find_rst_pt", found, 1);
      rst = 1'b1;
      step();
      chk("rst_a", int'(a), 0);
      chk("rst_av", int'(a_valid), 0);
      rst = 1'b0;
      steps(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/digit_scan_ctrl.md
Name: digit_scan_ctrl

Overview:
Scan sequencer that sits directly upstream of decoder_24. It generates the 2-bit select a[1:0] that decoder_24 turns into a one-hot y[3:0]. It steps through the four slots at a programmable rate, skipping masked-off slots. It also flags a select-valid qualifier and an end-of-frame pulse for the display/mux logic downstream.

Parameters:
PRESCALE, 4, clock cycles each slot is held; legal range 1..65535.
CNT_W, 16, prescale counter width; must satisfy 2^CNT_W >= PRESCALE.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous active-high reset.
en  input  1  scan enable; level-sensitive.
slot_mask  input  4  bit i=1 means slot i takes part in the scan.
a  output  2  slot select; drives decoder_24 a[1:0].
a_valid  output  1  high when a is a live slot select; downstream gates y with it.
frame_done  output  1  1-cycle pulse when the scan wraps to the start of a new frame.

Behaviour:
- Single clock domain.
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - On reset: a=2'b00, a_valid=0, frame_done=0, prescale counter=0, state=IDLE.
  - rst has priority over every other input.
  - rst asserted mid-scan returns the block to IDLE on that same edge.
- All outputs are registered. No combinational path from any input to any output.
- State IDLE:
  - a_valid=0, a holds its last value, counter=0.
  - Leave IDLE when en=1 and slot_mask!=0. On that edge: state=RUN, a=lowest set bit index of slot_mask, a_valid=1, counter=0, frame_done=0.
- State RUN:
  - counter increments each cycle.
  - When counter==PRESCALE-1 (terminal count):
    - counter returns to 0.
    - a moves to the next set bit of slot_mask strictly after the current a, searching circularly 0,1,2,3,0.
    - slot_mask is sampled only at terminal count. Mask changes mid-slot do not shorten the current slot.
    - frame_done=1 for exactly one cycle, in the cycle the new a appears, if the new index <= the old index (wrap). This includes the single-slot case, where a is unchanged and frame_done pulses every slot.
- RUN exits:
  - en=0 in RUN: next edge goes to IDLE, a_valid=0, counter=0, a holds. en has priority over terminal count.
  - slot_mask==0 sampled at terminal count: go to IDLE, a_valid=0, no frame_done.
- PRESCALE=1: a advances every cycle; a_valid stays high continuously.
- Slot period is PRESCALE cycles. With all four slots enabled, the frame period is 4*PRESCALE cycles.

Optional Feature:
Macro: SCAN_BLANK_EN
- Defined: adds a state BLANK between slots to stop ghosting on the display.
  - At terminal count, enter BLANK for exactly 1 cycle: a_valid=0, a already updated to the next slot, frame_done asserted in this cycle if the scan wrapped.
  - After BLANK: return to RUN with a_valid=1 and counter=0.
  - en=0 during BLANK: go to IDLE.
  - Slot period becomes PRESCALE+1 cycles.
- Undefined: no BLANK state; behaviour exactly as above and a_valid never drops between slots.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, then en=0, slot_mask=4'hF -> a=0, a_valid=0, frame_done=0 held indefinitely.
2. Full scan, PRESCALE=4: en=1, slot_mask=4'hF -> a_valid=1 one cycle after en. a runs 0,1,2,3,0, each held 4 cycles. frame_done pulses once per 16 cycles, coincident with a returning to 0. decoder_24 y shows 0001,0010,0100,1000.
3. Sparse mask: slot_mask=4'b1010 -> a alternates 1,3,1,3, 4 cycles each. frame_done pulses on each 3->1 transition.
4. Single slot plus mid-slot mask change: slot_mask=4'b0100 -> a=2 constant, frame_done every 4 cycles. Change the mask to 4'b0001 two cycles into a slot -> a stays 2 until terminal count, then becomes 0 with frame_done=1.
5. Disable/mask-zero/reset mid-scan:
   - en drops while a=2, counter=1 -> next edge a_valid=0, a=2 held.
   - Re-enable -> restart at the lowest set slot.
   - slot_mask=0 at terminal count -> IDLE with no frame_done.
   - rst pulse at counter=2 -> all outputs at reset values on that edge.
6. SCAN_BLANK_EN defined, PRESCALE=4, slot_mask=4'hF -> each slot is a_valid high 4 cycles then low 1 cycle, frame period 20 cycles. frame_done coincides with the BLANK cycle where a becomes 0.
